// File: rtl/alu_seq_if.sv
// alu_seq_if: start/op/operand bus and result/status bus of alu_seq.
// master = issuing stage (drives op), slave = ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ctl;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] dataOut;
  logic             zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div0;

  modport master (
    output start, ctl, dataA, dataB,
    input  dataOut, zero, hi, lo, busy, done, div0
  );

  modport slave (
    input  start, ctl, dataA, dataB,
    output dataOut, zero, hi, lo, busy, done, div0
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with iterative unsigned MULTU/DIVU into HI/LO.
// Optional divider: define ALU_DIV_EN to compile in the DIV state, restoring
// divider and div0 flag; otherwise DIVU acts as an unknown op.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULTU = 4'b1000,
    OP_DIVU  = 4'b1001,
    OP_MFHI  = 4'b1010,
    OP_MFLO  = 4'b1011,
    OP_NOR   = 4'b1100
  } op_e;

  state_e             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               pend;
  logic               fin;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     msum;
  logic [WIDTH-1:0]   res;
  logic               accept, start_mul, start_div, last;

  // The cycle after acceptance has busy=0 while the FSM already iterates,
  // so acceptance is also gated on the FSM being idle.
  assign accept    = bus.start && !bus.busy && (state == IDLE);
  assign start_mul = accept && (bus.ctl == OP_MULTU);
`ifdef ALU_DIV_EN
  assign start_div = accept && (bus.ctl == OP_DIVU) && (bus.dataB != '0);
`else
  assign start_div = 1'b0;
`endif
  assign last = (state != IDLE) && (cnt == CNT_W'(WIDTH - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_mul)      state_nx = MUL;
        else if (start_div) state_nx = DIV;
      end
      MUL, DIV: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture op and operands on the accepting edge; flag single-cycle work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      pend <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= bus.ctl;
        a_q  <= bus.dataA;
        b_q  <= bus.dataB;
      end
      pend <= accept && !start_mul && !start_div;
    end
  end

  // Iteration counter and end-of-iteration marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      fin <= 1'b0;
    end else begin
      if (state != IDLE) cnt <= last ? '0 : cnt + 1'b1;
      fin <= last;
    end
  end

  // Shift-add step: conditionally add multiplicand to upper half, carry kept
  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
  end

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   dtrial, ddiff;
  logic             dge;
  logic [WIDTH-1:0] drem;

  // Restoring step: shift next dividend bit into remainder, trial-subtract
  always_comb begin
    dtrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ddiff  = dtrial - {1'b0, b_q};
    dge    = !ddiff[WIDTH];
    drem   = dge ? ddiff[WIDTH-1:0] : dtrial[WIDTH-1:0];
  end
`endif

  // Shared accumulator: {partial product} or {remainder, quotient}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (start_mul) acc <= {{WIDTH{1'b0}}, bus.dataB};
    else if (start_div) acc <= {{WIDTH{1'b0}}, bus.dataA};
    else if (state == MUL) acc <= {msum, acc[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    else if (state == DIV) acc <= {drem, acc[WIDTH-2:0], dge};
`endif
  end

  // Single-cycle result
  always_comb begin
    res = '0;
    case (op_q)
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_ADD:  res = a_q + b_q;
      OP_SUB:  res = a_q - b_q;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_NOR:  res = ~(a_q | b_q);
      OP_MFHI: res = bus.hi;
      OP_MFLO: res = bus.lo;
      default: res = '0;
    endcase
  end

  // Architectural outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dataOut <= '0;
      bus.zero    <= 1'b0;
      bus.hi      <= '0;
      bus.lo      <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.div0    <= 1'b0;
    end else begin
      bus.busy <= (state != IDLE);
      bus.done <= fin || pend;
      if (fin) begin
        bus.hi <= acc[2*WIDTH-1:WIDTH];
        bus.lo <= acc[WIDTH-1:0];
      end
      if (pend) begin
`ifdef ALU_DIV_EN
        if (op_q == OP_DIVU) begin
          bus.hi   <= a_q;
          bus.lo   <= '1;
          bus.div0 <= 1'b1;
        end else
`endif
        begin
          bus.dataOut <= res;
          bus.zero    <= (res == '0);
        end
      end
`ifdef ALU_DIV_EN
      // Placed after the set so a MULTU/DIVU accepted in the same cycle wins
      if (accept && (bus.ctl == OP_MULTU || bus.ctl == OP_DIVU)) bus.div0 <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32 and WIDTH=8).
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nerr;
  int   bc;
  int   dk;

  alu_seq_if #(.WIDTH(32)) bi32 ();
  alu_seq_if #(.WIDTH(8))  bi8  ();

  alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bi32.slave));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bi8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bi32.start = 1'b1;
    bi32.ctl   = op;
    bi32.dataA = a;
    bi32.dataB = b;
    step();
    bi32.start = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bi8.start = 1'b1;
    bi8.ctl   = op;
    bi8.dataA = a;
    bi8.dataB = b;
    step();
    bi8.start = 1'b0;
  endtask

  // Wait for done on the 32-bit unit; optionally inject an ADD start at step inj
  task automatic run32(input int inj, output int busy_cnt, output int done_k);
    busy_cnt = 0;
    done_k   = 0;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      if (k == inj) begin
        bi32.start = 1'b1;
        bi32.ctl   = 4'b0010;
        bi32.dataA = 32'd1;
        bi32.dataB = 32'd1;
      end
      step();
      bi32.start = 1'b0;
      if (bi32.busy) busy_cnt++;
      if (bi32.done) done_k = k;
    end
  endtask

  task automatic run8(output int busy_cnt, output int done_k);
    busy_cnt = 0;
    done_k   = 0;
    for (int k = 1; k <= 20 && done_k == 0; k++) begin
      step();
      if (bi8.busy) busy_cnt++;
      if (bi8.done) done_k = k;
    end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    rst_n = 1'b1;
    bi32.start = 1'b0; bi32.ctl = '0; bi32.dataA = '0; bi32.dataB = '0;
    bi8.start  = 1'b0; bi8.ctl  = '0; bi8.dataA  = '0; bi8.dataB  = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(bi32.busy), 64'd0);
    chk("rst_done", 64'(bi32.done), 64'd0);
    chk("rst_dout", 64'(bi32.dataOut), 64'd0);
    chk("rst_hilo", {bi32.hi, bi32.lo}, 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // single-cycle ops
    issue32(4'b0110, 32'd5, 32'd5);
    chk("sub_done_early", 64'(bi32.done), 64'd0);
    step();
    chk("sub_dout", 64'(bi32.dataOut), 64'd0);
    chk("sub_zero", 64'(bi32.zero), 64'd1);
    chk("sub_done", 64'(bi32.done), 64'd1);
    chk("sub_busy", 64'(bi32.busy), 64'd0);

    issue32(4'b0010, 32'hFFFF_FFFF, 32'd2);
    step();
    chk("add_wrap", 64'(bi32.dataOut), 64'd1);
    chk("add_zero", 64'(bi32.zero), 64'd0);

    // back-to-back SLTs
    issue32(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
    issue32(4'b0111, 32'h8000_0000, 32'd1);
    chk("slt_pos_neg", 64'(bi32.dataOut), 64'd0);
    chk("slt_b2b_done1", 64'(bi32.done), 64'd1);
    step();
    chk("slt_neg_pos", 64'(bi32.dataOut), 64'd1);
    chk("slt_b2b_done2", 64'(bi32.done), 64'd1);
    step();
    chk("done_drop", 64'(bi32.done), 64'd0);

    issue32(4'b1100, 32'd0, 32'd0);
    step();
    chk("nor", 64'(bi32.dataOut), 64'hFFFF_FFFF);
    issue32(4'b0001, 32'hF0, 32'h0F);
    step();
    chk("or", 64'(bi32.dataOut), 64'hFF);
    issue32(4'b0000, 32'hF0F0, 32'hFF00);
    step();
    chk("and", 64'(bi32.dataOut), 64'hF000);
    issue32(4'b0011, 32'd5, 32'd7);
    step();
    chk("unk_dout", 64'(bi32.dataOut), 64'd0);
    chk("unk_zero", 64'(bi32.zero), 64'd1);
    chk("unk_done", 64'(bi32.done), 64'd1);

    // MULTU max with a start injected while busy
    issue32(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run32(5, bc, dk);
    chk("mul_busy_cycles", 64'(bc), 64'd32);
    chk("mul_done_at", 64'(dk), 64'd33);
    chk("mul_hi", 64'(bi32.hi), 64'hFFFF_FFFE);
    chk("mul_lo", 64'(bi32.lo), 64'h0000_0001);
    chk("mul_busy_end", 64'(bi32.busy), 64'd0);
    chk("mul_ignored_start", 64'(bi32.dataOut), 64'd0);
    issue32(4'b1010, 32'd0, 32'd0);
    chk("mfhi_pulse_once", 64'(bi32.done), 64'd0);
    step();
    chk("mfhi_new_hi", 64'(bi32.dataOut), 64'hFFFF_FFFE);
    chk("mfhi_done", 64'(bi32.done), 64'd1);

`ifdef ALU_DIV_EN
    issue32(4'b1001, 32'd100, 32'd7);
    run32(0, bc, dk);
    chk("div_busy_cycles", 64'(bc), 64'd32);
    chk("div_done_at", 64'(dk), 64'd33);
    chk("div_lo", 64'(bi32.lo), 64'd14);
    chk("div_hi", 64'(bi32.hi), 64'd2);
    issue32(4'b1011, 32'd0, 32'd0);
    step();
    chk("mflo_quot", 64'(bi32.dataOut), 64'd14);

    issue32(4'b1001, 32'd123, 32'd0);
    chk("div0_done_early", 64'(bi32.done), 64'd0);
    step();
    chk("div0_done", 64'(bi32.done), 64'd1);
    chk("div0_lo", 64'(bi32.lo), 64'hFFFF_FFFF);
    chk("div0_hi", 64'(bi32.hi), 64'd123);
    chk("div0_flag", 64'(bi32.div0), 64'd1);
    chk("div0_busy", 64'(bi32.busy), 64'd0);

    issue32(4'b1000, 32'd3, 32'd4);
    chk("div0_clear", 64'(bi32.div0), 64'd0);
    run32(0, bc, dk);
    chk("mul34_done_at", 64'(dk), 64'd33);
    chk("mul34_lo", 64'(bi32.lo), 64'd12);
    chk("mul34_hi", 64'(bi32.hi), 64'd0);
`else
    issue32(4'b1001, 32'd100, 32'd7);
    step();
    chk("nodiv_done", 64'(bi32.done), 64'd1);
    chk("nodiv_dout", 64'(bi32.dataOut), 64'd0);
    chk("nodiv_zero", 64'(bi32.zero), 64'd1);
    chk("nodiv_hilo", {bi32.hi, bi32.lo}, 64'hFFFF_FFFE_0000_0001);
    chk("nodiv_busy", 64'(bi32.busy), 64'd0);
    issue32(4'b1001, 32'd123, 32'd0);
    step();
    chk("nodiv_div0", 64'(bi32.div0), 64'd0);
    chk("nodiv0_hilo", {bi32.hi, bi32.lo}, 64'hFFFF_FFFE_0000_0001);
`endif

    // reset in the middle of a MULTU
    issue32(4'b1000, 32'd3, 32'd5);
    step(); step(); step(); step();
    chk("pre_rst_busy", 64'(bi32.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(bi32.busy), 64'd0);
    chk("mrst_hilo", {bi32.hi, bi32.lo}, 64'd0);
    chk("mrst_dout", 64'(bi32.dataOut), 64'd0);
    chk("mrst_flags", {61'd0, bi32.done, bi32.div0, bi32.zero}, 64'd0);
    #2 rst_n = 1'b1;
    step(); step(); step();
    chk("post_rst_busy", 64'(bi32.busy), 64'd0);
    chk("post_rst_hilo", {bi32.hi, bi32.lo}, 64'd0);
    chk("post_rst_done", 64'(bi32.done), 64'd0);

    // WIDTH=8 instance
    issue8(4'b1000, 8'hFF, 8'h02);
    run8(bc, dk);
    chk("w8_busy_cycles", 64'(bc), 64'd8);
    chk("w8_done_at", 64'(dk), 64'd9);
    chk("w8_hi", 64'(bi8.hi), 64'h01);
    chk("w8_lo", 64'(bi8.lo), 64'hFE);
`ifdef ALU_DIV_EN
    issue8(4'b1001, 8'hFE, 8'h10);
    run8(bc, dk);
    chk("w8_div_done_at", 64'(dk), 64'd9);
    chk("w8_div_lo", 64'(bi8.lo), 64'h0F);
    chk("w8_div_hi", 64'(bi8.hi), 64'h0E);
`else
    issue8(4'b0010, 8'd1, 8'd1);
    step();
    chk("w8_add", 64'(bi8.dataOut), 64'd2);
    issue8(4'b1001, 8'hFE, 8'h10);
    step();
    chk("w8_nodiv_zero", 64'(bi8.zero), 64'd1);
    chk("w8_nodiv_dout", 64'(bi8.dataOut), 64'd0);
    chk("w8_nodiv_hilo", 64'({bi8.hi, bi8.lo}), 64'h01FE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the datapath ALU for the MIPS core. It executes single-cycle logic/arithmetic ops with a registered result. It adds iterative unsigned multiply and divide into HI/LO registers behind a start/busy/done handshake. It sits in the EX stage; the hazard unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32: operand/result width, ≥4, power of two.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.
- `clk` input 1: clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: launch op on `ctl` with `dataA`/`dataB`; accepted only while `busy`=0.
- `ctl` input 4: op select.
- `dataA` input WIDTH: operand A (multiplicand/dividend).
- `dataB` input WIDTH: operand B (multiplier/divisor).
- `dataOut` output WIDTH: registered result of single-cycle ops.
- `zero` output 1: registered, 1 when the result written to `dataOut` is all zeros.
- `hi`, `lo` output WIDTH: product high/low, or remainder/quotient.
- `busy` output 1: multi-cycle op in progress.
- `done` output 1: one-cycle pulse when any accepted op completes.
- `div0` output 1: sticky flag, set by DIVU with `dataB`=0, cleared by the next accepted DIVU/MULTU.

## Operation
- Op codes for single-cycle ops: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, MFHI 1010, MFLO 1011.
- Op codes for multi-cycle ops: MULTU 1000, DIVU 1001.
- Any other code: `dataOut`=0, `zero`=1, `done` pulses.
- ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
- SLT is a true signed compare, including the overflow case: it returns 1 if $signed(A)<$signed(B), else 0, zero-extended to WIDTH.
- MFHI/MFLO copy `hi`/`lo` into `dataOut`.
- Operands and `ctl` are captured on the accepting edge; later input changes have no effect.
- State machine states: IDLE, MUL, DIV.
  - IDLE→MUL on accepted MULTU. IDLE→DIV on accepted DIVU with B≠0.
  - MUL→IDLE and DIV→IDLE when the counter reaches WIDTH-1.
  - Single-cycle ops stay in IDLE.
- MUL: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first. Result: `hi`:`lo` = A·B.
- DIV: restoring division, one quotient bit per cycle, MSB first. Result: `lo` = A/B, `hi` = A%B.
- DIVU with B=0: no DIV state. Next cycle `lo`=all ones, `hi`=A, `div0`=1, `done` pulses.
- `hi`/`lo` change only on MULTU/DIVU completion. `dataOut`/`zero` change only on single-cycle op completion.
- `start` while `busy`=1 is ignored; no queuing and no error.
- Reset, including mid-operation: state IDLE, counter 0, all outputs 0 (`dataOut`, `hi`, `lo`, `busy`, `done`, `div0`, `zero`), partial result discarded.

## Timing
- Single-cycle op accepted at edge N: `dataOut`/`zero` valid and `done`=1 after edge N+1; `busy` stays 0. Back-to-back issue every cycle is allowed.
- MULTU/DIVU accepted at edge N:
  - `busy`=1 after edges N+1 … N+WIDTH.
  - After edge N+WIDTH+1: `hi`/`lo` valid, `done`=1, `busy`=0.
  - A new `start` is accepted in the same cycle `done` is high.
- `done` is high for exactly one cycle per accepted op.
- MFHI issued in the `done` cycle of MULTU returns the new `hi`.

## Configuration
- `ALU_DIV_EN` defined: DIV state, restoring divider and `div0` logic are compiled in, as described above.
- `ALU_DIV_EN` undefined:
  - DIVU behaves as an unknown op: `dataOut`=0, `zero`=1, `done` next cycle.
  - `hi`/`lo` are unchanged.
  - `div0` is tied to 0.
  - No divider logic is synthesised.

## Test plan
- Reset: drive `rst_n`=0 mid-MULTU (cycle 5) → all outputs 0 immediately; after release, `busy`=0 and `hi`=`lo`=0.
- Single-cycle ops, WIDTH=32:
  - SUB 5−5 → `dataOut`=0, `zero`=1, `done` at N+1.
  - SLT A=0x7FFFFFFF, B=0x80000000 → `dataOut`=0.
  - SLT A=0x80000000, B=1 → `dataOut`=1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `busy` high exactly 32 cycles; `done` at N+33. A `start` issued during `busy` is ignored.
- DIVU 100/7 → `lo`=14, `hi`=2, `done` at N+33. Then MFLO in the `done` cycle → `dataOut`=14.
- DIVU 123/0 → `lo`=0xFFFFFFFF, `hi`=123, `div0`=1, `done` at N+1. A following MULTU 3×4 clears `div0` and gives `lo`=12.
- Recompile with WIDTH=8: MULTU 0xFF×0x02 → `hi`=0x01, `lo`=0xFE, `done` at N+9. Also without `ALU_DIV_EN`: DIVU → `zero`=1 and `hi`/`lo` unchanged.
